// File: rtl/fp_round_pack.sv
// fp_round_pack
//   Two-stage back end for the binary32 multiplier. It takes the raw 48-bit
//   significand product, the two biased exponents, the operand classes and
//   the result sign. It normalizes, rounds to nearest-even, resolves special
//   operands and overflow/underflow, and packs an IEEE-754 binary32 word.
//   Stage 1 registers the normalized fields. Stage 2 rounds, packs and drives
//   the outputs. Both sides use valid/ready handshakes, and a result is held
//   stable while the consumer stalls.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   upstream presents a product
//   in_ready    out  block accepts on in_valid & in_ready
//   in_sign     in   sign_a ^ sign_b
//   in_exp_a/b  in   8-bit biased exponent fields
//   in_class_a/b in  00 normal, 01 zero/subnormal, 10 inf, 11 NaN
//   in_mant     in   48-bit product {1,fracA}*{1,fracB}
//   out_valid   out  result valid, held until out_ready
//   out_ready   in   downstream accepts
//   out_result  out  packed binary32
//   out_flags   out  {invalid, overflow, underflow, inexact}
module fp_round_pack #(
  parameter int BIAS  = 127,
  parameter int EXP_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp_a,
  input  logic [7:0]  in_exp_b,
  input  logic [1:0]  in_class_a,
  input  logic [1:0]  in_class_b,
  input  logic [47:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);

  // Operand-class outcome, resolved in stage 1 so stage 2 only has to pack.
  typedef enum logic [2:0] {
    SP_NONE    = 3'd0,
    SP_QNAN    = 3'd1,
    SP_INVALID = 3'd2,
    SP_INF     = 3'd3,
    SP_ZERO    = 3'd4
  } special_e;

  // Handshake / advance
  logic w_s1_adv;
  logic w_s2_adv;

  logic                    r_s1_valid;
  logic                    r_s1_sign;
  logic signed [EXP_W-1:0] r_s1_exp;
  logic [22:0]             r_s1_frac;
  logic                    r_s1_g;
  logic                    r_s1_s;
  special_e                r_s1_spec;

  logic        r_s2_valid;
  logic [31:0] r_s2_result;
  logic [3:0]  r_s2_flags;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_flags  = r_s2_flags;

  // Stage 1: normalize
  logic                    w_norm;
  logic signed [EXP_W-1:0] w_exp;
  logic [22:0]             w_frac;
  logic                    w_g;
  logic                    w_s;
  special_e                w_spec;

  assign w_norm = in_mant[47];
  assign w_exp  = EXP_W'(in_exp_a) + EXP_W'(in_exp_b) - EXP_W'(BIAS) + EXP_W'(w_norm);

  always_comb begin
    if (w_norm) begin
      w_frac = in_mant[46:24];
      w_g    = in_mant[23];
      w_s    = |in_mant[22:0];
    end else begin
      w_frac = in_mant[45:23];
      w_g    = in_mant[22];
      w_s    = |in_mant[21:0];
    end
  end

  always_comb begin
    w_spec = SP_NONE;
    if ((in_class_a == CLS_INF && in_class_b == CLS_ZERO) ||
        (in_class_a == CLS_ZERO && in_class_b == CLS_INF))
      w_spec = SP_INVALID;
    else if (in_class_a == CLS_NAN || in_class_b == CLS_NAN)
      w_spec = SP_QNAN;
    else if (in_class_a == CLS_INF || in_class_b == CLS_INF)
      w_spec = SP_INF;
    else if (in_class_a == CLS_ZERO || in_class_b == CLS_ZERO)
      w_spec = SP_ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_frac  <= '0;
      r_s1_g     <= 1'b0;
      r_s1_s     <= 1'b0;
      r_s1_spec  <= SP_NONE;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_sign;
        r_s1_exp  <= w_exp;
        r_s1_frac <= w_frac;
        r_s1_g    <= w_g;
        r_s1_s    <= w_s;
        r_s1_spec <= w_spec;
      end
    end
  end

  // Stage 2: round to nearest-even, classify, pack
  logic                    w_up;
  logic [23:0]             w_rnd;
  logic signed [EXP_W-1:0] w_exp_r;
  logic                    w_inexact;
  logic [31:0]             w_res;
  logic [3:0]              w_flags;

  assign w_up      = r_s1_g && (r_s1_s || r_s1_frac[0]);
  assign w_rnd     = {1'b0, r_s1_frac} + 24'(w_up);
  // A carry out leaves w_rnd[22:0] all zero, so only the exponent moves.
  assign w_exp_r   = r_s1_exp + EXP_W'(w_rnd[23]);
  assign w_inexact = r_s1_g || r_s1_s;

  always_comb begin
    w_res   = {r_s1_sign, w_exp_r[7:0], w_rnd[22:0]};
    w_flags = {3'b000, w_inexact};
    case (r_s1_spec)
      SP_INVALID: begin
        w_res   = 32'h7FC0_0000;
        w_flags = 4'b1000;
      end
      SP_QNAN: begin
        w_res   = 32'h7FC0_0000;
        w_flags = 4'b0000;
      end
      SP_INF: begin
        w_res   = {r_s1_sign, 8'hFF, 23'h0};
        w_flags = 4'b0000;
      end
      SP_ZERO: begin
        w_res   = {r_s1_sign, 31'h0};
        w_flags = 4'b0000;
      end
      default: begin
        if (w_exp_r >= EXP_MAX) begin
          w_res   = {r_s1_sign, 8'hFF, 23'h0};
          w_flags = 4'b0101;
        end else if (w_exp_r <= EXP_ZERO) begin
          // No subnormal outputs: flush to signed zero.
          w_res   = {r_s1_sign, 31'h0};
          w_flags = 4'b0011;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_res;
        r_s2_flags  <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
module tb_fp_round_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp_a = '0;
  logic [7:0]  in_exp_b = '0;
  logic [1:0]  in_class_a = '0;
  logic [1:0]  in_class_b = '0;
  logic [47:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  fp_round_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp_a   (in_exp_a),
    .in_exp_b   (in_exp_b),
    .in_class_a (in_class_a),
    .in_class_b (in_class_b),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  logic rand_bp = 1'b0;
  logic bp_force = 1'b1;

  logic        held_v = 1'b0;
  logic [31:0] held_r = '0;
  logic [3:0]  held_f = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [1:0] cls(input logic [31:0] x);
    if (x[30:23] == 8'd0)   return 2'b01;
    if (x[30:23] == 8'd255) return (x[22:0] != 0) ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  // Reference: exact integer product, then round to nearest-even using the
  // discarded remainder compared against one half ulp.
  function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [1:0] ca, cb;
    logic s;
    longint unsigned m, q, rem, half;
    int e, sh;
    logic inv;
    ca = cls(a);
    cb = cls(b);
    s  = a[31] ^ b[31];
    inv = (ca == 2'b10 && cb == 2'b01) || (ca == 2'b01 && cb == 2'b10);
    if (inv || ca == 2'b11 || cb == 2'b11) begin
      r.res = 32'h7FC0_0000;
      r.flg = {inv, 3'b000};
      return r;
    end
    if (ca == 2'b10 || cb == 2'b10) begin
      r.res = {s, 8'hFF, 23'h0};
      r.flg = 4'b0000;
      return r;
    end
    if (ca == 2'b01 || cb == 2'b01) begin
      r.res = {s, 31'h0};
      r.flg = 4'b0000;
      return r;
    end
    m  = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = (m >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e = e + 1;
    q    = m >> sh;
    rem  = m & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      r.res = {s, 8'hFF, 23'h0};
      r.flg = 4'b0101;
    end else if (e <= 0) begin
      r.res = {s, 31'h0};
      r.flg = 4'b0011;
    end else begin
      r.res = {s, 8'(e), q[22:0]};
      r.flg = {3'b000, rem != 0};
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    int unsigned sel;
    logic [7:0]  e;
    logic [22:0] f;
    sel = $urandom_range(0, 15);
    f   = 23'($urandom);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) begin
      e = 8'd255;
      if ($urandom_range(0, 1) == 0) f = '0;
    end
    else if (sel < 4)  e = 8'($urandom_range(190, 254));
    else if (sel < 6)  e = 8'($urandom_range(1, 64));
    else               e = 8'($urandom_range(64, 190));
    if ($urandom_range(0, 3) == 0) f[11:0] = '0;
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t ex);
    logic acc;
    in_valid   = 1'b1;
    in_sign    = a[31] ^ b[31];
    in_exp_a   = a[30:23];
    in_exp_b   = b[30:23];
    in_class_a = cls(a);
    in_class_b = cls(b);
    in_mant    = 48'({40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]});
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sb.push_back(ex);
        n_acc++;
        in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_ref(input logic [31:0] a, input logic [31:0] b);
    send(a, b, ref_mul(a, b));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : bp_force;
    end
  end

  // Scoreboard and hold-stability monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_result", out_result, held_r);
          chk("hold_flags", out_flags, held_f);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_out", out_valid, 0);
          else begin
            e = sb.pop_front();
            n_pop++;
            chk("result", out_result, e.res);
            chk("flags", out_flags, e.flg);
          end
        end
        held_v = out_valid && !out_ready;
        held_r = out_result;
        held_f = out_flags;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1);
  end

  initial begin
    int base;
    int pb;
    logic [31:0] a, b;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_flags", out_flags, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1.5 x 2.0 with latency check
    send(32'h3FC0_0000, 32'h4000_0000, '{32'h4040_0000, 4'b0000});
    @(negedge clk);
    chk("latency_c1", out_valid, 0);
    @(negedge clk);
    chk("latency_c2", out_valid, 1);
    @(posedge clk);
    #1;

    // Ties, overflow/underflow, specials, back to back
    send(32'h3F80_0001, 32'h3FC0_0000, '{32'h3FC0_0002, 4'b0001});
    send(32'h3F80_0003, 32'h3FC0_0000, '{32'h3FC0_0004, 4'b0001});
    send(32'h7F00_0000, 32'h4000_0000, '{32'h7F80_0000, 4'b0101});
    send(32'h0080_0000, 32'h3F00_0000, '{32'h0000_0000, 4'b0011});
    send(32'h7F80_0000, 32'h0000_0000, '{32'h7FC0_0000, 4'b1000});
    send(32'hFF80_0000, 32'h4000_0000, '{32'hFF80_0000, 4'b0000});
    send(32'h8000_0000, 32'h40A0_0000, '{32'h8000_0000, 4'b0000});
    send(32'h7FC0_1234, 32'h3F80_0000, '{32'h7FC0_0000, 4'b0000});
    wait_drain();

    // Backpressure: 4 pushes against a stalled consumer
    bp_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    base = n_acc;
    pb   = n_pop;
    fork
      begin
        for (int k = 0; k < 4; k++) send_ref(32'h3F80_0000 | 23'($urandom), 32'h4000_0000 | 23'($urandom));
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    chk("bp_accepted", n_acc - base, 2);
    chk("bp_in_ready", in_ready, 0);
    bp_force = 1'b1;
    wait fork;
    wait_drain();
    chk("bp_delivered", n_pop - pb, 4);

    // Reset with two results in flight
    bp_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_ref(32'h4040_0000, 32'h4040_0000);
    send_ref(32'h40A0_0000, 32'h3FC0_0000);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready", in_ready, 1);
    sb.delete();
    bp_force = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(32'h4000_0000, 32'h4040_0000, '{32'h40C0_0000, 4'b0000});
    wait_drain();

    // Randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      a = rnd_fp();
      b = rnd_fp();
      send_ref(a, b);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_bp  = 1'b0;
    bp_force = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
